// File: rtl/synth_pkg.sv
// synth_pkg: shared definitions for the synth voice stages (state encoding, sample width).
package synth_pkg;
    localparam int SAMPLE_W = 8;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running prescaler that pulses Tick once every TICK_DIV clocks.
module tick_divider #(
    parameter int TICK_DIV = 256
) (
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] count;
    assign Tick = count == LAST;
    always_ff @(posedge Clock or posedge Reset)
        if (Reset) count <= '0;
        else count <= Tick ? '0 : count + 1'b1;
endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope applied to the waveform generator output.
// Define ADSR_EXP_RELEASE_EN for an exponential-like release tail instead of linear.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int TICK_DIV = 256
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Gate,
    input  logic [SAMPLE_W-1:0] AttackRate,
    input  logic [SAMPLE_W-1:0] DecayRate,
    input  logic [SAMPLE_W-1:0] Sustain,
    input  logic [SAMPLE_W-1:0] ReleaseRate,
    input  logic [SAMPLE_W-1:0] Waveform,
    output logic [SAMPLE_W-1:0] Sample,
    output logic [SAMPLE_W-1:0] EnvLevel,
    output logic                Active
);
    state_t state, state_n;
    logic [SAMPLE_W-1:0] level, level_n, rel_step;
    logic [SAMPLE_W:0] attack_sum;
    logic gate_d, tick, rise, fall;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (.Clock(Clock), .Reset(Reset), .Tick(tick));

    assign rise = Gate & ~gate_d;
    assign fall = ~Gate & gate_d;
    assign attack_sum = {1'b0, level} + {1'b0, AttackRate};
    assign EnvLevel = level;

`ifdef ADSR_EXP_RELEASE_EN
    logic [SAMPLE_W-1:0] rel_scaled;
    assign rel_scaled = SAMPLE_W'((16'(level) * 16'(ReleaseRate)) >> 8);
    // never stall the tail once a non-zero rate is requested
    assign rel_step = (ReleaseRate != '0 && rel_scaled == '0) ? SAMPLE_W'(1) : rel_scaled;
`else
    assign rel_step = ReleaseRate;
`endif

    always_comb begin
        state_n = state;
        level_n = level;
        if (rise) state_n = ATTACK;
        else if (fall) state_n = (state == IDLE || state == RELEASE) ? state : RELEASE;
        else if (state == SUSTAIN) level_n = Sustain;
        else if (tick)
            case (state)
                ATTACK: begin
                    state_n = attack_sum >= 9'd255 ? DECAY : ATTACK;
                    level_n = attack_sum >= 9'd255 ? 8'd255 : attack_sum[SAMPLE_W-1:0];
                end
                DECAY: begin
                    state_n = {1'b0, level} <= {1'b0, Sustain} + {1'b0, DecayRate} ? SUSTAIN : DECAY;
                    level_n = {1'b0, level} <= {1'b0, Sustain} + {1'b0, DecayRate} ? Sustain : level - DecayRate;
                end
                RELEASE: begin
                    state_n = (ReleaseRate != '0 && level <= ReleaseRate) ? IDLE : RELEASE;
                    level_n = (ReleaseRate != '0 && level <= ReleaseRate) ? '0 : level - rel_step;
                end
                default: ;
            endcase
    end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state  <= IDLE;
            level  <= '0;
            gate_d <= 1'b0;
            Sample <= '0;
            Active <= 1'b0;
        end else begin
            state  <= state_n;
            level  <= level_n;
            gate_d <= Gate;
            Sample <= SAMPLE_W'((16'(Waveform) * (16'(level) + 16'd1)) >> 8);
            Active <= state_n != IDLE;
        end
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table vectors, hand sequences and a random run against a reference model.
module tb_adsr_envelope;
    logic Clock = 0, Reset = 0, Gate = 0;
    logic [7:0] AttackRate = 0, DecayRate = 0, Sustain = 0, ReleaseRate = 0, Waveform = 0;
    logic [7:0] smp1, env1, smp4, env4;
    logic act1, act4;
    int checks = 0, failures = 0;

`ifdef ADSR_EXP_RELEASE_EN
    localparam bit EXP = 1;
    localparam int REL1 = 89;
`else
    localparam bit EXP = 0;
    localparam int REL1 = 70;
`endif

    adsr_envelope #(.TICK_DIV(1)) u1 (.Clock(Clock), .Reset(Reset), .Gate(Gate), .AttackRate(AttackRate),
        .DecayRate(DecayRate), .Sustain(Sustain), .ReleaseRate(ReleaseRate), .Waveform(Waveform),
        .Sample(smp1), .EnvLevel(env1), .Active(act1));
    adsr_envelope #(.TICK_DIV(4)) u4 (.Clock(Clock), .Reset(Reset), .Gate(Gate), .AttackRate(AttackRate),
        .DecayRate(DecayRate), .Sustain(Sustain), .ReleaseRate(ReleaseRate), .Waveform(Waveform),
        .Sample(smp4), .EnvLevel(env4), .Active(act4));

    always #5 Clock = ~Clock;

    // reference: phase letters I/A/D/S/R, level as plain integer
    int m_lvl[2], m_smp[2], m_cnt[2];
    byte m_ph[2];
    bit m_gd[2], m_act[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 0; m_smp[k] = 0; m_cnt[k] = 0; m_ph[k] = "I"; m_gd[k] = 0; m_act[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int div = k ? 4 : 1;
            bit tk = m_cnt[k] == div - 1;
            bit r = Gate && !m_gd[k];
            bit f = !Gate && m_gd[k];
            int ar = int'(AttackRate), dr = int'(DecayRate), sus = int'(Sustain), rr = int'(ReleaseRate);
            int step;
            m_cnt[k] = (m_cnt[k] + 1) % div;
            m_gd[k] = Gate;
            m_smp[k] = (int'(Waveform) * (m_lvl[k] + 1)) / 256;
            if (r) m_ph[k] = "A";
            else if (f) begin
                if (m_ph[k] inside {"A", "D", "S"}) m_ph[k] = "R";
            end else if (m_ph[k] == "S") m_lvl[k] = sus;
            else if (tk) begin
                if (m_ph[k] == "A") begin
                    if (m_lvl[k] + ar >= 255) begin m_lvl[k] = 255; m_ph[k] = "D"; end
                    else m_lvl[k] += ar;
                end else if (m_ph[k] == "D") begin
                    if (m_lvl[k] <= sus + dr) begin m_lvl[k] = sus; m_ph[k] = "S"; end
                    else m_lvl[k] -= dr;
                end else if (m_ph[k] == "R") begin
                    step = EXP ? (rr == 0 ? 0 : ((m_lvl[k] * rr) / 256 > 0 ? (m_lvl[k] * rr) / 256 : 1)) : rr;
                    if (rr != 0 && m_lvl[k] <= rr) begin m_lvl[k] = 0; m_ph[k] = "I"; end
                    else m_lvl[k] -= step;
                end
            end
            m_act[k] = m_ph[k] != "I";
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_env_div1", int'(env1), m_lvl[0]);
        check("model_smp_div1", int'(smp1), m_smp[0]);
        check("model_act_div1", int'(act1), int'(m_act[0]));
        check("model_env_div4", int'(env4), m_lvl[1]);
        check("model_smp_div4", int'(smp4), m_smp[1]);
        check("model_act_div4", int'(act4), int'(m_act[1]));
    endtask

    task automatic cyc();
        @(posedge Clock);
        model_edge();
        #1;
        compare_model();
    endtask

    // asynchronous pulse placed between clock edges
    task automatic pulse_reset();
        #2 Reset = 1;
        model_reset();
        #1;
        check("rst_env1", int'(env1), 0); check("rst_smp1", int'(smp1), 0); check("rst_act1", int'(act1), 0);
        check("rst_env4", int'(env4), 0); check("rst_smp4", int'(smp4), 0); check("rst_act4", int'(act4), 0);
        #1 Reset = 0;
    endtask

    typedef struct {
        bit g;
        int ar, sus, env, smp;
        bit act, lin;
    } vec_t;
    vec_t tbl[33];
    int exp4[8] = '{0, 0, 0, 64, 64, 64, 64, 128};
    int exp1[2] = '{0, 64};

    initial begin
        tbl[0]  = '{1, 64, 100,   0,   0, 1, 0};
        tbl[1]  = '{1, 64, 100,  64,   0, 1, 0};
        tbl[2]  = '{1, 64, 100, 128,  50, 1, 0};
        tbl[3]  = '{1, 64, 100, 192, 100, 1, 0};
        tbl[4]  = '{1, 64, 100, 255, 150, 1, 0};
        tbl[5]  = '{1, 64, 100, 205, 200, 1, 0};
        tbl[6]  = '{1, 64, 100, 155, 160, 1, 0};
        tbl[7]  = '{1, 64, 100, 105, 121, 1, 0};
        tbl[8]  = '{1, 64, 100, 100,  82, 1, 0};
        tbl[9]  = '{1, 64,  80,  80,  78, 1, 0};
        tbl[10] = '{1, 64, 100, 100,  63, 1, 0};
        tbl[11] = '{0, 64, 100, 100,  78, 1, 0};
        tbl[12] = '{0, 64, 100, REL1, 78, 1, 0};
        tbl[13] = '{0, 64, 100,  40,  -1, 1, 1};
        tbl[14] = '{1, 64, 100,  40,  -1, 1, 1};
        tbl[15] = '{1, 64, 100, 104,  -1, 1, 1};
        tbl[16] = '{1, 64, 100, 168,  -1, 1, 1};
        tbl[17] = '{1, 64, 100, 232,  -1, 1, 1};
        tbl[18] = '{1, 64, 100, 255,  -1, 1, 1};
        tbl[19] = '{1, 64, 100, 205,  -1, 1, 1};
        tbl[20] = '{1, 64, 100, 155,  -1, 1, 1};
        tbl[21] = '{1, 64, 100, 105,  -1, 1, 1};
        tbl[22] = '{1, 64, 100, 100,  -1, 1, 1};
        tbl[23] = '{0, 64, 100, 100,  -1, 1, 1};
        tbl[24] = '{0, 64, 100,  70,  -1, 1, 1};
        tbl[25] = '{0, 64, 100,  40,  -1, 1, 1};
        tbl[26] = '{0, 64, 100,  10,  -1, 1, 1};
        tbl[27] = '{0, 64, 100,   0,  -1, 0, 1};
        tbl[28] = '{0, 64, 100,   0,  -1, 0, 1};
        tbl[29] = '{1, 127, 100,  0,   0, 1, 1};
        tbl[30] = '{1, 127, 100, 127,  0, 1, 1};
        tbl[31] = '{1, 127, 100, 254, 100, 1, 1};
        tbl[32] = '{1, 127, 100, 255, 199, 1, 1};

        model_reset();
        #1 Reset = 1;
        #1;
        check("init_env", int'(env1), 0); check("init_smp", int'(smp1), 0); check("init_act", int'(act1), 0);
        check("init_env4", int'(env4), 0); check("init_smp4", int'(smp4), 0); check("init_act4", int'(act4), 0);
        @(posedge Clock);
        #2 Reset = 0;

        DecayRate = 50; ReleaseRate = 30; Waveform = 200;
        for (int i = 0; i < 33; i++) begin
            Gate = tbl[i].g; AttackRate = 8'(tbl[i].ar); Sustain = 8'(tbl[i].sus);
            cyc();
            if (!(EXP && tbl[i].lin)) begin
                check($sformatf("vec%0d_env", i), int'(env1), tbl[i].env);
                check($sformatf("vec%0d_act", i), int'(act1), int'(tbl[i].act));
                if (tbl[i].smp >= 0) check($sformatf("vec%0d_smp", i), int'(smp1), tbl[i].smp);
            end
        end

        // reset in the middle of an attack with Gate held high
        Gate = 0; ReleaseRate = 255;
        repeat (3) cyc();
        Gate = 1; AttackRate = 64;
        cyc(); cyc();
        check("pre_rst_env1", int'(env1), 64);
        pulse_reset();
        for (int j = 0; j < 8; j++) begin
            cyc();
            check($sformatf("div4_env%0d", j), int'(env4), exp4[j]);
            check($sformatf("div4_act%0d", j), int'(act4), 1);
            if (j < 2) check($sformatf("restart_env%0d", j), int'(env1), exp1[j]);
        end

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(15) == 0) Gate = ~Gate;
            if ($urandom_range(63) == 0) begin
                AttackRate  = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(255));
                DecayRate   = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(255));
                ReleaseRate = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(255));
            end
            if ($urandom_range(31) == 0) Sustain = 8'($urandom_range(255));
            Waveform = 8'($urandom_range(255));
            cyc();
            if ($urandom_range(599) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Downstream stage of the 8-bit waveform generator. Applies an ADSR (attack/decay/sustain/release) amplitude envelope to its unsigned 8-bit Waveform output.
- Driven by a note Gate. Produces the scaled Sample that feeds the mixer/DAC stage.
- The envelope level advances once per prescaled tick. Sample scaling is registered every clock.

Parameters:
- TICK_DIV, 256: clocks per envelope tick. Legal range is 1..65536. A value of 1 means every clock is a tick.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Gate  input  1  note on/off, synchronous to Clock.
- AttackRate  input  8  level increment per tick in ATTACK. 0 = hold.
- DecayRate  input  8  level decrement per tick in DECAY. 0 = hold.
- Sustain  input  8  sustain level.
- ReleaseRate  input  8  level decrement per tick in RELEASE. 0 = hold.
- Waveform  input  8  unsigned sample from the waveform generator. Must be driven; WaveType 2'b11 floats it and is illegal here.
- Sample  output  8  enveloped sample, registered.
- EnvLevel  output  8  current envelope level.
- Active  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high), all cleared immediately:
  - state = IDLE, level = 0, Sample = 0, Active = 0.
  - prescaler = 0, gate_d = 0.
- Gate handling:
  - gate_d registers Gate each clock.
  - rise = Gate & ~gate_d; fall = ~Gate & gate_d.
  - If Gate is high when Reset deasserts, the first clock sees a rise.
- Prescaler:
  - Free-running counter over 0..TICK_DIV-1. tick = (count == TICK_DIV-1).
  - Not reset by Gate.
- Priority within a cycle: rise > fall > tick step.
- Gate transitions take effect on the clock edge where the edge is seen, independent of tick.
- A rise or fall cycle performs no level step, even if tick is high.
- State transitions:
  - IDLE: rise -> ATTACK. Level stays 0.
  - Any state: rise -> ATTACK. Level is kept (retrigger from the current level, no reset to 0).
  - ATTACK, DECAY, SUSTAIN: fall -> RELEASE.
  - fall in IDLE or RELEASE: ignored.
- Per-tick level steps:
  - ATTACK:
    - 9-bit sum = level + AttackRate.
    - If sum >= 255: level = 255 and go to DECAY. Otherwise level = sum.
  - DECAY:
    - If level <= Sustain + DecayRate (compare 9-bit, no underflow): level = Sustain and go to SUSTAIN.
    - Otherwise level -= DecayRate.
    - DecayRate = 0 holds level in DECAY, except when level <= Sustain.
  - SUSTAIN:
    - level = Sustain every clock, tick not required. This tracks live Sustain changes.
  - RELEASE:
    - If ReleaseRate != 0 and level <= ReleaseRate: level = 0 and go to IDLE.
    - Otherwise level -= ReleaseRate.
- Sample scaling:
  - Sample <= (Waveform * (level + 1)) >> 8, computed in 16 bits.
  - One-cycle latency, using Waveform and level of the same cycle.
  - level = 255 passes Waveform unchanged. level = 0 gives 0.
- EnvLevel = level, registered.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: the RELEASE step is (level * ReleaseRate) >> 8, forced to a minimum of 1 when ReleaseRate != 0. The result is an exponential-like tail. The exit rule is unchanged.
- Undefined: linear release as described above. No extra multiplier is present.

Decomposition:
- Shared package synth_pkg holds:
  - State encoding localparams: IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4.
  - Width constant SAMPLE_W = 8, shared with the waveform generator.
- One sub-module, tick_divider:
  - Parameter TICK_DIV.
  - Ports Clock, Reset, Tick.
  - Reusable by other synth stages.

Test Plan:
All cases use TICK_DIV = 1 unless noted.
1. Attack: Reset, then Gate = 1, AttackRate = 64 -> EnvLevel 64, 128, 192, 255 on successive ticks, then state DECAY. Active = 1 from the rise edge.
2. Decay: from 255 with DecayRate = 50, Sustain = 100 -> 205, 155, 105, 100, then SUSTAIN. Changing Sustain to 80 -> EnvLevel = 80 next clock.
3. Release: Gate low at level 100 with ReleaseRate = 30 -> 70, 40, 10, 0, then IDLE with Active = 0. Repeat with ADSR_EXP_RELEASE_EN: first step 100 -> 89.
4. Retrigger: Gate rises during RELEASE at level 40 with AttackRate = 64 -> ATTACK, then 104. Simultaneous rise + tick -> no step that cycle.
5. Scaling: Waveform = 200 with level 255 / 127 / 0 -> Sample 200 / 100 / 0, each one clock later. Repeat with TICK_DIV = 4: level changes only every 4th clock.
6. Async reset mid-ATTACK: pulse Reset between clock edges -> Sample, EnvLevel and Active = 0 immediately. With Gate still high, ATTACK restarts from 0 after release of Reset.
